alu_result_stage: RTL and testbench

Registered output stage directly downstream of the N-bit ALU. Captures each ALU Result together with the Opcode that produced it, and buffers up to 2 entries in a FIFO with a valid/ready handshake. Attaches zero and parity flags to each entry. Counts completed transfers so the consumer (writeback/display logic) can stall without losing ALU results.

---
 rtl/alu_result_stage.sv | 101 ++++++++++
 tb/tb_alu_result_stage.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/alu_result_stage.sv
// rtl/alu_result_stage.sv - two-entry result FIFO behind the ALU with zero/parity flags and transfer counter
module alu_result_stage #(
    parameter int N_ALU = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N_ALU-1:0] in_result,
    input  logic [1:0]       in_opcode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N_ALU-1:0] out_result,
    output logic [1:0]       out_opcode,
    output logic             out_zero,
    output logic             out_parity,
    output logic [CNT_W-1:0] txn_count
);

    logic [N_ALU-1:0] mem_result [2];
    logic [1:0]       mem_opcode [2];
    logic             mem_zero   [2];
    logic             mem_parity [2];

    logic       wptr;
    logic       rptr;
    logic [1:0] occ;

    logic       push;
    logic       pop;
    logic       rptr_n;
    logic [1:0] occ_n;
    logic       in_zero;
    logic       in_parity;

    assign in_ready  = (occ != 2'd2);
    assign out_valid = (occ != 2'd0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign rptr_n    = rptr ^ pop;
    assign in_zero   = (in_result == '0);
    assign in_parity = ^in_result;

    always_comb begin
        occ_n = occ;
        case ({push, pop})
            2'b10:   occ_n = occ + 2'd1;
            2'b01:   occ_n = occ - 2'd1;
            default: occ_n = occ;
        endcase
    end

    // The head is kept in its own registers so the outputs come straight from
    // flops and keep the last head value once the FIFO drains.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                mem_result[i] <= '0;
                mem_opcode[i] <= '0;
                mem_zero[i]   <= 1'b0;
                mem_parity[i] <= 1'b0;
            end
            wptr       <= 1'b0;
            rptr       <= 1'b0;
            occ        <= 2'd0;
            txn_count  <= '0;
            out_result <= '0;
            out_opcode <= '0;
            out_zero   <= 1'b0;
            out_parity <= 1'b0;
        end else begin
            if (push) begin
                mem_result[wptr] <= in_result;
                mem_opcode[wptr] <= in_opcode;
                mem_zero[wptr]   <= in_zero;
                mem_parity[wptr] <= in_parity;
                wptr             <= ~wptr;
            end
            if (pop && (txn_count != '1)) begin
                txn_count <= txn_count + 1'b1;
            end
            rptr <= rptr_n;
            occ  <= occ_n;
            if (occ_n != 2'd0) begin
                if (push && (wptr == rptr_n)) begin
                    out_result <= in_result;
                    out_opcode <= in_opcode;
                    out_zero   <= in_zero;
                    out_parity <= in_parity;
                end else begin
                    out_result <= mem_result[rptr_n];
                    out_opcode <= mem_opcode[rptr_n];
                    out_zero   <= mem_zero[rptr_n];
                    out_parity <= mem_parity[rptr_n];
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_result_stage.sv
// tb/tb_alu_result_stage.sv - directed self-checking bench for alu_result_stage
module tb_alu_result_stage;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_result;
    logic [1:0] in_opcode;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_result;
    logic [1:0] out_opcode;
    logic       out_zero;
    logic       out_parity;
    logic [7:0] txn_count;

    logic       s_in_ready;
    logic       s_out_valid;
    logic [3:0] s_out_result;
    logic [1:0] s_out_opcode;
    logic       s_out_zero;
    logic       s_out_parity;
    logic [2:0] s_txn_count;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    alu_result_stage #(.N_ALU(4), .CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_result(in_result), .in_opcode(in_opcode),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_opcode(out_opcode),
        .out_zero(out_zero), .out_parity(out_parity),
        .txn_count(txn_count)
    );

    alu_result_stage #(.N_ALU(4), .CNT_W(3)) dut_s (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(s_in_ready),
        .in_result(in_result), .in_opcode(in_opcode),
        .out_valid(s_out_valid), .out_ready(out_ready),
        .out_result(s_out_result), .out_opcode(s_out_opcode),
        .out_zero(s_out_zero), .out_parity(s_out_parity),
        .txn_count(s_txn_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_result = 4'h0;
        in_opcode = 2'd0;
        step();
        step();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_txn", 32'(txn_count), 32'd0);
        chk("rst_result", 32'(out_result), 32'd0);
        chk("rst_opcode", 32'(out_opcode), 32'd0);
        chk("rst_zero", 32'(out_zero), 32'd0);
        chk("rst_parity", 32'(out_parity), 32'd0);
        rst = 1'b0;

        // asynchronous reset with no clock edge
        in_valid = 1'b1; in_result = 4'h9; in_opcode = 2'd2;
        step();
        in_valid = 1'b0;
        chk("async_pre_valid", 32'(out_valid), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("async_out_valid", 32'(out_valid), 32'd0);
        chk("async_in_ready", 32'(in_ready), 32'd1);
        chk("async_txn", 32'(txn_count), 32'd0);
        chk("async_result", 32'(out_result), 32'd0);
        step();
        rst = 1'b0;

        // single transfer
        in_valid = 1'b1; in_result = 4'h0; in_opcode = 2'd3; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        chk("single_valid", 32'(out_valid), 32'd1);
        chk("single_result", 32'(out_result), 32'd0);
        chk("single_opcode", 32'(out_opcode), 32'd3);
        chk("single_zero", 32'(out_zero), 32'd1);
        chk("single_parity", 32'(out_parity), 32'd0);
        chk("single_txn0", 32'(txn_count), 32'd0);
        step();
        chk("single_txn1", 32'(txn_count), 32'd1);
        chk("single_empty", 32'(out_valid), 32'd0);

        // backpressure and ordering
        out_ready = 1'b0;
        in_valid = 1'b1; in_result = 4'h7; in_opcode = 2'd0;
        step();
        chk("bp_ready_occ1", 32'(in_ready), 32'd1);
        in_result = 4'h3; in_opcode = 2'd1;
        step();
        chk("bp_full_ready", 32'(in_ready), 32'd0);
        in_result = 4'hF; in_opcode = 2'd2;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("bp_hold_ready", 32'(in_ready), 32'd0);
            chk("bp_hold_result", 32'(out_result), 32'h7);
            chk("bp_hold_parity", 32'(out_parity), 32'd1);
            chk("bp_hold_opcode", 32'(out_opcode), 32'd0);
        end
        out_ready = 1'b1;
        step();
        chk("bp_second_result", 32'(out_result), 32'h3);
        chk("bp_second_parity", 32'(out_parity), 32'd0);
        chk("bp_second_opcode", 32'(out_opcode), 32'd1);
        chk("bp_ready_back", 32'(in_ready), 32'd1);
        chk("bp_txn2", 32'(txn_count), 32'd2);
        step();
        in_valid = 1'b0;
        chk("bp_f_result", 32'(out_result), 32'hF);
        chk("bp_f_opcode", 32'(out_opcode), 32'd2);
        chk("bp_f_parity", 32'(out_parity), 32'd0);
        chk("bp_f_zero", 32'(out_zero), 32'd0);
        chk("bp_f_valid", 32'(out_valid), 32'd1);
        step();
        chk("bp_drained", 32'(out_valid), 32'd0);
        chk("bp_txn4", 32'(txn_count), 32'd4);

        // streaming at occupancy 1, plus saturation of the narrow counter
        #2 rst = 1'b1;
        #1 rst = 1'b0;
        chk("stream_rst_txn", 32'(txn_count), 32'd0);
        out_ready = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            in_valid  = 1'b1;
            in_result = i[3:0];
            in_opcode = i[1:0];
            step();
            chk("stream_valid", 32'(out_valid), 32'd1);
            chk("stream_in_ready", 32'(in_ready), 32'd1);
            chk("stream_result", 32'(out_result), 32'(i[3:0]));
            chk("stream_opcode", 32'(out_opcode), 32'(i[1:0]));
            chk("stream_parity", 32'(out_parity), 32'(^i[3:0]));
            chk("stream_txn", 32'(txn_count), 32'(i - 1));
            chk("sat_txn", 32'(s_txn_count), 32'((i - 1) > 7 ? 7 : (i - 1)));
        end
        in_valid = 1'b0;
        step();
        chk("stream_final_txn", 32'(txn_count), 32'd10);
        chk("sat_final_txn", 32'(s_txn_count), 32'd7);
        chk("stream_empty", 32'(out_valid), 32'd0);
        chk("stream_hold_last", 32'(out_result), 32'hA);

        // reset while full
        out_ready = 1'b0;
        in_valid = 1'b1; in_result = 4'h1; in_opcode = 2'd0;
        step();
        in_result = 4'h2;
        step();
        in_valid = 1'b0;
        chk("rstmid_full", 32'(in_ready), 32'd0);
        #2 rst = 1'b1;
        #1;
        chk("rstmid_valid", 32'(out_valid), 32'd0);
        chk("rstmid_txn", 32'(txn_count), 32'd0);
        chk("rstmid_ready", 32'(in_ready), 32'd1);
        step();
        rst = 1'b0;
        in_valid = 1'b1; in_result = 4'h5; in_opcode = 2'd1;
        step();
        in_valid = 1'b0;
        chk("rstmid_push_valid", 32'(out_valid), 32'd1);
        chk("rstmid_push_result", 32'(out_result), 32'h5);
        chk("rstmid_push_zero", 32'(out_zero), 32'd0);
        chk("rstmid_push_parity", 32'(out_parity), 32'd0);
        out_ready = 1'b1;
        step();
        chk("rstmid_alone", 32'(out_valid), 32'd0);
        chk("rstmid_txn1", 32'(txn_count), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
